// File: rtl/bus_master_arbiter_if.sv
// Per-master REQ/ACK transaction port of the basil bus master arbiter.
// The master modport drives the request, the slave modport answers it.
interface bus_master_arbiter_if #(
    parameter int ABUSWIDTH = 16,
    parameter int DBUSWIDTH = 8
);
    logic                 REQ;
    logic                 WE;
    logic [ABUSWIDTH-1:0] ADD;
    logic [DBUSWIDTH-1:0] WDATA;
    logic                 ACK;
    logic [DBUSWIDTH-1:0] RDATA;

    modport master (
        output REQ,
        output WE,
        output ADD,
        output WDATA,
        input  ACK,
        input  RDATA
    );

    modport slave (
        input  REQ,
        input  WE,
        input  ADD,
        input  WDATA,
        output ACK,
        output RDATA
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing one basil register bus between two masters.
// One transaction in flight; strobe, fixed read latency, registered ACK.
module bus_master_arbiter #(
    parameter int ABUSWIDTH  = 16,
    parameter int DBUSWIDTH  = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    bus_master_arbiter_if.slave  M0,
    bus_master_arbiter_if.slave  M1,
    output logic                 BUS_RD,
    output logic                 BUS_WR,
    output logic [ABUSWIDTH-1:0] BUS_ADD,
    output logic [DBUSWIDTH-1:0] BUS_WDATA,
    input  logic [DBUSWIDTH-1:0] BUS_RDATA,
    output logic [1:0]           GRANT
);
    localparam int CW = $clog2(RD_LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 ptr_q, ptr_d;
    logic                 we_q, we_d;
    logic [ABUSWIDTH-1:0] add_q, add_d;
    logic [DBUSWIDTH-1:0] wdata_q, wdata_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           ack_q, ack_d;
    logic [DBUSWIDTH-1:0] rdata0_q, rdata0_d;
    logic [DBUSWIDTH-1:0] rdata1_q, rdata1_d;

    logic [1:0]           req;
    logic                 pick;
    logic                 sel_we;
    logic [ABUSWIDTH-1:0] sel_add;
    logic [DBUSWIDTH-1:0] sel_wdata;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        we_d      = we_q;
        add_d     = add_q;
        wdata_d   = '0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        cnt_d     = cnt_q;
        ack_d     = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        req       = {M1.REQ, M0.REQ};
        pick      = 1'b0;
        sel_we    = M0.WE;
        sel_add   = M0.ADD;
        sel_wdata = M0.WDATA;

        unique case (state_q)
            IDLE: begin
                grant_d = 2'b00;
                add_d   = '0;
                // pick = 1 selects M1; the pointer only moves on contention
                unique case (1'b1)
                    (req == 2'b11): begin
                        pick  = ptr_q;
                        ptr_d = ~ptr_q;
                    end
                    (req == 2'b01): pick = 1'b0;
                    (req == 2'b10): pick = 1'b1;
                    default: pick = 1'b0;
                endcase
                if (pick) begin
                    sel_we    = M1.WE;
                    sel_add   = M1.ADD;
                    sel_wdata = M1.WDATA;
                end
                if (|req) begin
                    state_d = ISSUE;
                    grant_d = pick ? 2'b10 : 2'b01;
                    we_d    = sel_we;
                    add_d   = sel_add;
                    wr_d    = sel_we;
                    rd_d    = ~sel_we;
                    wdata_d = sel_we ? sel_wdata : '0;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                    ack_d   = grant_q;
                end else begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    ack_d   = grant_q;
                    if (grant_q[0]) rdata0_d = BUS_RDATA;
                    if (grant_q[1]) rdata1_d = BUS_RDATA;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
                add_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            ptr_q    <= 1'b0;
            we_q     <= 1'b0;
            add_q    <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            ack_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            add_q    <= add_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign BUS_RD    = rd_q;
    assign BUS_WR    = wr_q;
    assign BUS_ADD   = add_q;
    assign BUS_WDATA = wdata_q;
    assign GRANT     = grant_q;
    assign M0.ACK    = ack_q[0];
    assign M1.ACK    = ack_q[1];
    assign M0.RDATA  = rdata0_q;
    assign M1.RDATA  = rdata1_q;

    a_one_strobe: assert property (@(posedge BUS_CLK) disable iff (!BUS_RST_N)
        !(BUS_RD && BUS_WR));
    a_grant_1hot: assert property (@(posedge BUS_CLK) disable iff (!BUS_RST_N)
        $onehot0(GRANT));
    a_strobe_st: assert property (@(posedge BUS_CLK) disable iff (!BUS_RST_N)
        (BUS_RD || BUS_WR) |-> (state_q == ISSUE));
endmodule
